// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle unsigned multiply/divide sequencer.
// It borrows the CPU's shared add/sub ALU for one iteration per cycle.
// MULU uses shift-add and DIVU uses restoring division. The result lands
// in HI/LO and is held there until the next accepted start.
module alu_muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_own,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam int                CNT_W    = $clog2(ITERS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERS - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;      // 0 = MULU, 1 = DIVU
  logic [WIDTH-1:0] r_a;       // latched multiplicand / dividend
  logic [WIDTH-1:0] r_b;       // latched multiplier M / divisor D
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH-1:0] w_shift;   // divide: partial remainder shifted left by one
  logic             w_top;     // divide: bit shifted out of the remainder
  logic             w_carry;   // multiply: carry-out recovered from the ALU sum
  logic             w_sub_ok;  // divide: subtraction is kept (quotient bit = 1)

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign alu_own = (r_state == S_ITER);
  assign hi      = r_hi;
  assign lo      = r_lo;

  assign w_shift  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_top    = r_hi[WIDTH-1];
  // The ALU has no carry-out. A wrapped unsigned sum is smaller than an addend.
  assign w_carry  = (alu_res < r_hi);
  // If the bit shifted out is set, the true remainder is at least 2^WIDTH, which exceeds D.
  assign w_sub_ok = w_top | (w_shift >= r_b);

  // Steer the shared ALU while iterating. It rests at 0 + 0 otherwise.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_ADD;
    if (alu_own) begin
      if (r_op) begin
        alu_a  = w_shift;
        alu_b  = r_b;
        alu_op = ALU_SUB;
      end else begin
        alu_a  = r_hi;
        alu_b  = r_b;
        alu_op = ALU_ADD;
      end
    end
  end

  // Sequencer FSM, iteration counter and HI/LO datapath.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a_in;
            r_b     <= b_in;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt <= '0;
          if (r_op && (r_b == '0)) begin
            // Divide by zero completes at once: quotient all ones, remainder = dividend.
            r_hi    <= r_a;
            r_lo    <= '1;
            r_state <= S_DONE;
          end else begin
            r_hi    <= '0;
            r_lo    <= r_a;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) r_state <= S_DONE;
          if (!r_op) begin
            if (r_lo[0]) {r_hi, r_lo} <= {w_carry, alu_res, r_lo[WIDTH-1:1]};
            else         {r_hi, r_lo} <= {1'b0, r_hi, r_lo[WIDTH-1:1]};
          end else if (w_sub_ok) begin
            r_hi <= alu_res;
            r_lo <= {r_lo[WIDTH-2:0], 1'b1};
          end else begin
            r_hi <= w_shift;
            r_lo <= {r_lo[WIDTH-2:0], 1'b0};
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// tb_alu_muldiv_seq: scoreboard bench for the multiply/divide sequencer.
// The bench models the shared ALU. Expected HI/LO values come from plain
// 64-bit arithmetic. They are queued when an operation is issued and
// compared when done pulses.
module tb_alu_muldiv_seq;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_own;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_res;

  res_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_muldiv_seq #(.WIDTH(32), .ITERS(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a_in    (a_in),
    .b_in    (b_in),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo),
    .alu_own (alu_own),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_res (alu_res)
  );

  // The CPU's shared ALU: add or subtract, no carry-out.
  assign alu_res = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic res_t model(input logic o, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    logic [63:0] p;
    if (!o) begin
      p = 64'(a) * 64'(b);
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (b == 32'd0) begin
      r.hi = a;
      r.lo = 32'hFFFF_FFFF;
    end else begin
      r.hi = a % b;
      r.lo = a / b;
    end
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        res_t e;
        e = sb.pop_front();
        check("hi", 64'(hi), 64'(e.hi));
        check("lo", 64'(lo), 64'(e.lo));
      end
    end
  end

  // Issue one operation and track it cycle by cycle. Cycle k is sampled at
  // the negedge that follows edge E0+k. inj_cyc >= 0 pulses a conflicting
  // start in that cycle. rst_cyc >= 0 asserts reset in that cycle and ends
  // the operation early.
  task automatic run_op(input string name, input logic o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_done, input int exp_own,
                        input int inj_cyc, input int rst_cyc);
    int k        = 0;
    int busy_n   = 0;
    int own_n    = 0;
    int done_n   = 0;
    int done_cyc = -1;
    int bad_idle = 0;
    int bad_op   = 0;
    @(negedge clk);
    op = o; a_in = a; b_in = b; start = 1'b1;
    sb.push_back(model(o, a, b));
    @(negedge clk);
    // Scramble the request inputs while busy. They must have no effect.
    start = 1'b0; op = ~o; a_in = $urandom; b_in = $urandom;
    while (k < 100) begin
      if (busy) busy_n++;
      if (alu_own) begin
        own_n++;
        if (alu_op !== (o ? 3'b001 : 3'b000)) bad_op++;
      end else if ((alu_a | alu_b | 32'(alu_op)) != 32'd0) begin
        bad_idle++;
      end
      if (done) begin
        done_n++;
        done_cyc = k;
      end
      if (!busy) break;
      if (k == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check({name, "_rst_busy"}, 64'(busy), 64'd0);
        check({name, "_rst_hi"}, 64'(hi), 64'd0);
        check({name, "_rst_lo"}, 64'(lo), 64'd0);
        check({name, "_rst_own"}, 64'(alu_own), 64'd0);
        check({name, "_rst_done"}, 64'(done_n + int'(done)), 64'd0);
        sb.delete();
        return;
      end
      if (k == inj_cyc) begin
        start = 1'b1; op = 1'b0; a_in = 32'd9; b_in = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check({name, "_idle_cycle"}, 64'(k), 64'(exp_done + 1));
    check({name, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({name, "_done_pulses"}, 64'(done_n), 64'd1);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(exp_done + 1));
    check({name, "_own_cycles"}, 64'(own_n), 64'(exp_own));
    check({name, "_alu_op"}, 64'(bad_op), 64'd0);
    check({name, "_alu_idle_zero"}, 64'(bad_idle), 64'd0);
  endtask

  // Hold start high across two operations. They must complete 35 cycles apart.
  task automatic back_to_back();
    int first  = -1;
    int second = -1;
    @(negedge clk);
    op = 1'b0; a_in = 32'd5; b_in = 32'd11; start = 1'b1;
    sb.push_back(model(1'b0, 32'd5, 32'd11));
    sb.push_back(model(1'b0, 32'd5, 32'd11));
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done) begin
        if (first < 0) first = k;
        else begin
          second = k;
          start  = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    check("b2b_spacing", 64'(second - first), 64'd35);
    for (int k = 0; k < 5 && busy; k++) @(negedge clk);
    check("b2b_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_own", 64'(alu_own), 64'd0);
    check("rst_alu", {alu_a, alu_b[28:0], alu_op}, 64'd0);

    run_op("mul_7x6",  1'b0, 32'd7,          32'd6,          33, 32, -1, -1);
    run_op("mul_max",  1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  33, 32, -1, -1);
    run_op("div_100",  1'b1, 32'd100,        32'd7,          33, 32, -1, -1);
    run_op("div_top",  1'b1, 32'hFFFF_FFFF,  32'h8000_0001,  33, 32, -1, -1);
    run_op("div_zero", 1'b1, 32'd123,        32'd0,           1,  0, -1, -1);
    run_op("mul_ign",  1'b0, 32'd3,          32'd5,          33, 32, 10, -1);
    run_op("mul_9x9",  1'b0, 32'd9,          32'd9,          33, 32, -1, -1);
    run_op("div_rst",  1'b1, 32'd100,        32'd7,          33, 32, -1, 20);
    run_op("mul_2x3",  1'b0, 32'd2,          32'd3,          33, 32, -1, -1);
    run_op("div_rand", 1'b1, 32'hDEAD_BEEF,  32'h0001_2345,  33, 32, -1, -1);
    back_to_back();

    repeat (2) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
